pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_unit.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address width,
// forward-select encodings and the memory-access FSM state type.
package pipe_pkg;

    localparam int REG_W = 3;

    typedef logic [REG_W-1:0] regAddrT;
    typedef logic [1:0]       fwdSelT;

    localparam fwdSelT FWD_REG = 2'b00;
    localparam fwdSelT FWD_MEM = 2'b10;
    localparam fwdSelT FWD_WB  = 2'b01;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } memStateT;

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding: picks the youngest in-flight producer of each EX source
// register, EX/MEM before MEM/WB, and never forwards R0.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rsEX,
    input  logic [REG_W-1:0] rtEX,
    input  logic [REG_W-1:0] rdMEM,
    input  logic             regWriteMEM,
    input  logic [REG_W-1:0] rdWB,
    input  logic             regWriteWB,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB
);

    function automatic fwdSelT selectSrc(
        input regAddrT src,
        input regAddrT rdM,
        input logic    wrM,
        input regAddrT rdW,
        input logic    wrW
    );
        fwdSelT sel;
        sel = FWD_REG;
        if (wrM && (rdM != '0) && (rdM == src)) begin
            sel = FWD_MEM;
        end else if (wrW && (rdW != '0) && (rdW == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign forwardA = selectSrc(rsEX, rdMEM, regWriteMEM, rdWB, regWriteWB);
    assign forwardB = selectSrc(rtEX, rdMEM, regWriteMEM, rdWB, regWriteWB);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and a
// data-memory wait FSM that freezes the whole pipeline until the access ends.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no access outstanding; a new request may complete zero-wait
//   MEM_WAIT | access outstanding, waiting for memAck or the timeout
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsID,
    input  logic [REG_W-1:0] rtID,
    input  logic [REG_W-1:0] rsEX,
    input  logic [REG_W-1:0] rtEX,
    input  logic [REG_W-1:0] rdEX,
    input  logic             memReadEX,
    input  logic             regWriteEX,
    input  logic [REG_W-1:0] rdMEM,
    input  logic             regWriteMEM,
    input  logic             memReadMEM,
    input  logic             memWriteMEM,
    input  logic [REG_W-1:0] rdWB,
    input  logic             regWriteWB,
    input  logic             branchTaken,
    input  logic             memAck,
    output logic             memReq,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExFlush,
    output logic             ifIdFlush,
    output logic             pipeFreeze,
    output logic             memErr,
    output logic [7:0]       stallCnt
);

    localparam logic [7:0] TIMEOUT_TC = 8'(MEM_TIMEOUT - 1);

    memStateT   state;
    logic [7:0] waitCnt;
    logic [7:0] nextCnt;
    logic       accessMEM;
    logic       loadUse;
    logic       stallCycle;

    // A load always writes its rd, so regWriteEX adds nothing to hazard detection.
    logic unusedRegWriteEX;
    assign unusedRegWriteEX = regWriteEX;

    fwd_unit uFwd (
        .rsEX        (rsEX),
        .rtEX        (rtEX),
        .rdMEM       (rdMEM),
        .regWriteMEM (regWriteMEM),
        .rdWB        (rdWB),
        .regWriteWB  (regWriteWB),
        .forwardA    (forwardA),
        .forwardB    (forwardB)
    );

    assign accessMEM  = memReadMEM | memWriteMEM;
    assign nextCnt    = waitCnt + 8'd1;
    assign memReq     = rst & (((state == IDLE) & accessMEM) | (state == MEM_WAIT));
    assign memErr     = (state == MEM_WAIT) & ~memAck & (nextCnt == TIMEOUT_TC);
    assign pipeFreeze = memReq & ~memAck & ~memErr;

    assign loadUse = memReadEX & (rdEX != '0) & ((rdEX == rsID) | (rdEX == rtID));

    // Freeze dominates; a pending branch or load-use is resolved once it lifts.
    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        idExFlush = 1'b0;
        ifIdFlush = 1'b0;
        if (pipeFreeze) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
        end else if (branchTaken) begin
            idExFlush = 1'b1;
            ifIdFlush = 1'b1;
        end else if (loadUse) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
        end
    end

    assign stallCycle = pipeFreeze | (loadUse & ~branchTaken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accessMEM && !memAck) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (memAck || memErr) begin
                        state <= IDLE;
                    end else begin
                        waitCnt <= nextCnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (stallCycle && (stallCnt != 8'hFF)) begin
            stallCnt <= stallCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by randomized cycles
// checked against an access-cycle-counting reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rsID, rtID, rsEX, rtEX, rdEX, rdMEM, rdWB;
    logic       memReadEX, regWriteEX, regWriteMEM, memReadMEM, memWriteMEM;
    logic       regWriteWB, branchTaken, memAck;
    logic       memReq, pcWrite, ifIdWrite, idExFlush, ifIdFlush, pipeFreeze, memErr;
    logic [1:0] forwardA, forwardB;
    logic [7:0] stallCnt;

    int nTests = 0;
    int nFail  = 0;

    // reference model state
    bit mInAccess;
    int mReqIdx;
    int mStall;

    // expected values for the current cycle
    int eFwdA, eFwdB, eK, eStall;
    bit eReq, eFreeze, eErr, ePc, eIfId, eIdExF, eIfIdF, eStallCycle;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rsID        (rsID),
        .rtID        (rtID),
        .rsEX        (rsEX),
        .rtEX        (rtEX),
        .rdEX        (rdEX),
        .memReadEX   (memReadEX),
        .regWriteEX  (regWriteEX),
        .rdMEM       (rdMEM),
        .regWriteMEM (regWriteMEM),
        .memReadMEM  (memReadMEM),
        .memWriteMEM (memWriteMEM),
        .rdWB        (rdWB),
        .regWriteWB  (regWriteWB),
        .branchTaken (branchTaken),
        .memAck      (memAck),
        .memReq      (memReq),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .pcWrite     (pcWrite),
        .ifIdWrite   (ifIdWrite),
        .idExFlush   (idExFlush),
        .ifIdFlush   (ifIdFlush),
        .pipeFreeze  (pipeFreeze),
        .memErr      (memErr),
        .stallCnt    (stallCnt)
    );

    always #5 clk = ~clk;

    task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idleInputs();
        rst = 1'b1;
        rsID = 0; rtID = 0; rsEX = 0; rtEX = 0; rdEX = 0; rdMEM = 0; rdWB = 0;
        memReadEX = 0; regWriteEX = 0; regWriteMEM = 0; memReadMEM = 0;
        memWriteMEM = 0; regWriteWB = 0; branchTaken = 0; memAck = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fwdExp(input logic [2:0] src);
        if (regWriteMEM && rdMEM != 0 && rdMEM == src) return 2;
        if (regWriteWB && rdWB != 0 && rdWB == src) return 1;
        return 0;
    endfunction

    task automatic computeExpect();
        bit lu;
        if (!rst) begin
            mInAccess = 0;
            mReqIdx   = 0;
            mStall    = 0;
        end
        eFwdA   = fwdExp(rsEX);
        eFwdB   = fwdExp(rtEX);
        eReq    = rst && (mInAccess || memReadMEM || memWriteMEM);
        eK      = mInAccess ? mReqIdx + 1 : 1;
        eErr    = eReq && !memAck && (eK == TIMEOUT);
        eFreeze = eReq && !memAck && !eErr;
        lu      = memReadEX && rdEX != 0 && (rdEX == rsID || rdEX == rtID);
        ePc = 1; eIfId = 1; eIdExF = 0; eIfIdF = 0;
        if (eFreeze) begin
            ePc = 0; eIfId = 0;
        end else if (branchTaken) begin
            eIdExF = 1; eIfIdF = 1;
        end else if (lu) begin
            ePc = 0; eIfId = 0; eIdExF = 1;
        end
        eStallCycle = eFreeze || (lu && !branchTaken);
        eStall      = mStall;
    endtask

    task automatic updateModel();
        if (!rst) begin
            mInAccess = 0;
            mReqIdx   = 0;
            mStall    = 0;
        end else begin
            mInAccess = eReq && !memAck && !eErr;
            mReqIdx   = mInAccess ? eK : 0;
            if (eStallCycle && mStall < 255) mStall++;
        end
    endtask

    task automatic checkAll();
        chkVal("rnd forwardA", 32'(forwardA), 32'(eFwdA));
        chkVal("rnd forwardB", 32'(forwardB), 32'(eFwdB));
        chkVal("rnd memReq", 32'(memReq), 32'(eReq));
        chkVal("rnd memErr", 32'(memErr), 32'(eErr));
        chkVal("rnd pipeFreeze", 32'(pipeFreeze), 32'(eFreeze));
        chkVal("rnd pcWrite", 32'(pcWrite), 32'(ePc));
        chkVal("rnd ifIdWrite", 32'(ifIdWrite), 32'(eIfId));
        chkVal("rnd idExFlush", 32'(idExFlush), 32'(eIdExF));
        chkVal("rnd ifIdFlush", 32'(ifIdFlush), 32'(eIfIdF));
        chkVal("rnd stallCnt", 32'(stallCnt), 32'(eStall));
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        memReadMEM = 1'b1;
        #2;
        chkVal("reset memReq", 32'(memReq), 0);
        chkVal("reset stallCnt", 32'(stallCnt), 0);
        chkVal("reset memErr", 32'(memErr), 0);
        repeat (2) tick();
        idleInputs();
        #2;
        chkVal("idle memReq", 32'(memReq), 0);
        chkVal("idle pcWrite", 32'(pcWrite), 1);
        chkVal("idle forwardA", 32'(forwardA), 0);

        // forwarding priority
        rdMEM = 3; regWriteMEM = 1; rsEX = 3; rdWB = 3; regWriteWB = 1; rtEX = 5;
        #1;
        chkVal("fwd mem priority", 32'(forwardA), 2);
        chkVal("fwd B none", 32'(forwardB), 0);
        rdMEM = 0;
        #1;
        chkVal("fwd wb", 32'(forwardA), 1);
        rdWB = 0; rsEX = 0;
        #1;
        chkVal("fwd r0", 32'(forwardA), 0);
        idleInputs();

        // load-use stall
        memReadEX = 1; rdEX = 2; rtID = 2;
        #1;
        chkVal("lu pcWrite", 32'(pcWrite), 0);
        chkVal("lu ifIdWrite", 32'(ifIdWrite), 0);
        chkVal("lu idExFlush", 32'(idExFlush), 1);
        chkVal("lu stallCnt before", 32'(stallCnt), 0);
        tick();
        idleInputs();
        #1;
        chkVal("lu pcWrite after", 32'(pcWrite), 1);
        chkVal("lu stallCnt after", 32'(stallCnt), 1);

        // read with ack in the third cycle
        memReadMEM = 1;
        for (int i = 1; i <= 3; i++) begin
            memAck = (i == 3);
            #1;
            chkVal($sformatf("rd%0d memReq", i), 32'(memReq), 1);
            chkVal($sformatf("rd%0d pipeFreeze", i), 32'(pipeFreeze), (i < 3) ? 1 : 0);
            tick();
        end
        idleInputs();
        #1;
        chkVal("rd done memReq", 32'(memReq), 0);
        chkVal("rd stallCnt", 32'(stallCnt), 3);

        // write timeout
        memWriteMEM = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chkVal($sformatf("to%0d memReq", i), 32'(memReq), 1);
            chkVal($sformatf("to%0d memErr", i), 32'(memErr), (i == 4) ? 1 : 0);
            chkVal($sformatf("to%0d pipeFreeze", i), 32'(pipeFreeze), (i < 4) ? 1 : 0);
            tick();
        end
        idleInputs();
        #1;
        chkVal("to done memReq", 32'(memReq), 0);
        chkVal("to done memErr", 32'(memErr), 0);
        chkVal("to stallCnt", 32'(stallCnt), 6);

        // branch over load-use, then the same during a freeze
        branchTaken = 1; memReadEX = 1; rdEX = 2; rsID = 2;
        #1;
        chkVal("br ifIdFlush", 32'(ifIdFlush), 1);
        chkVal("br idExFlush", 32'(idExFlush), 1);
        chkVal("br pcWrite", 32'(pcWrite), 1);
        tick();
        memReadMEM = 1;
        #1;
        chkVal("brfrz ifIdFlush", 32'(ifIdFlush), 0);
        chkVal("brfrz idExFlush", 32'(idExFlush), 0);
        chkVal("brfrz pcWrite", 32'(pcWrite), 0);
        tick();
        memAck = 1;
        #1;
        chkVal("brack ifIdFlush", 32'(ifIdFlush), 1);
        chkVal("brack idExFlush", 32'(idExFlush), 1);
        chkVal("brack pcWrite", 32'(pcWrite), 1);
        tick();
        idleInputs();
        #1;
        chkVal("br stallCnt", 32'(stallCnt), 7);

        // reset in MEM_WAIT
        memReadMEM = 1;
        tick();
        rdMEM = 3; regWriteMEM = 1; rsEX = 3;
        rst = 0;
        #1;
        chkVal("rstw memReq", 32'(memReq), 0);
        chkVal("rstw stallCnt", 32'(stallCnt), 0);
        chkVal("rstw memErr", 32'(memErr), 0);
        chkVal("rstw pipeFreeze", 32'(pipeFreeze), 0);
        chkVal("rstw forwardA", 32'(forwardA), 2);
        tick();
        idleInputs();
        #1;
        chkVal("rstw idle memReq", 32'(memReq), 0);

        // zero-wait access followed back-to-back by a waiting one
        memReadMEM = 1; memAck = 1;
        #1;
        chkVal("zw memReq", 32'(memReq), 1);
        chkVal("zw pipeFreeze", 32'(pipeFreeze), 0);
        tick();
        memAck = 0;
        #1;
        chkVal("b2b memReq", 32'(memReq), 1);
        chkVal("b2b pipeFreeze", 32'(pipeFreeze), 1);
        memAck = 1;
        tick();
        idleInputs();

        // randomized cycles against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst         = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            rsID        = 3'($urandom_range(0, 3));
            rtID        = 3'($urandom_range(0, 3));
            rsEX        = 3'($urandom_range(0, 3));
            rtEX        = 3'($urandom_range(0, 3));
            rdEX        = 3'($urandom_range(0, 3));
            rdMEM       = 3'($urandom_range(0, 3));
            rdWB        = 3'($urandom_range(0, 3));
            memReadEX   = ($urandom_range(0, 2) == 0);
            regWriteEX  = 1'($urandom_range(0, 1));
            regWriteMEM = 1'($urandom_range(0, 1));
            regWriteWB  = 1'($urandom_range(0, 1));
            memReadMEM  = ($urandom_range(0, 2) == 0);
            memWriteMEM = ($urandom_range(0, 3) == 0);
            branchTaken = ($urandom_range(0, 5) == 0);
            memAck      = ($urandom_range(0, 3) == 0);
            #2;
            computeExpect();
            checkAll();
            @(posedge clk);
            updateModel();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
